// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU command sequencer and its FIFO.
// Default widths, ALU in_sel control encodings and the sequencer FSM states.
package alu_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int ALU_OP_W   = 6;

    // in_sel bits: [2] persist, [1] load, [0] reset
    localparam logic [2:0] INSEL_IDLE    = 3'b000;
    localparam logic [2:0] INSEL_RESET   = 3'b001;
    localparam logic [2:0] INSEL_LOAD    = 3'b010;
    localparam logic [2:0] INSEL_PERSIST = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_CLR  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: synchronous, DEPTH entries, head presented combinationally on pop_dat.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push ignored when full (no same-cycle pop bypass); flush empties it.
module alu_cmd_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // power-of-two depth: pointers wrap by natural overflow
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ALU feeder: queues commands, drives load/persist on the ALU, captures and presents the result.
// Latency: command pushed at E0 into an idle block gives res_valid after E(2+SETTLE_CYCLES).
// Backpressure: cmd_ready = !full; result held in HOLD until res_ready, next command waits.
module alu_cmd_sequencer #(
    parameter int DATA_W        = alu_pkg::ALU_DATA_W,
    parameter int OP_W          = alu_pkg::ALU_OP_W,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    output logic [2:0]        alu_in_sel,
    output logic [DATA_W-1:0] alu_num1,
    output logic [DATA_W-1:0] alu_num2,
    output logic [OP_W-1:0]   alu_out_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [1:0]        alu_curr_state,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [OP_W-1:0]   res_op,
    output logic [1:0]        res_state,
    output logic              busy
);

    import alu_pkg::*;

    localparam int CMD_W = 2*DATA_W + OP_W;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        in_sel_q, in_sel_d;
    logic [DATA_W-1:0] num1_q, num1_d;
    logic [DATA_W-1:0] num2_q, num2_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [OP_W-1:0]   res_op_q, res_op_d;
    logic [1:0]        res_state_q, res_state_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic [CMD_W-1:0]  fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    logic [DATA_W-1:0] head_a;
    logic [DATA_W-1:0] head_b;
    logic [OP_W-1:0]   head_op;

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && !fifo_full && !flush;
    assign {head_a, head_b, head_op} = fifo_head;

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push     (fifo_push),
        .push_dat ({cmd_a, cmd_b, cmd_op}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_sel_d    = in_sel_q;
        num1_d      = num1_q;
        num2_d      = num2_q;
        op_d        = op_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        res_state_d = res_state_q;
        fifo_pop    = 1'b0;

        if (flush) begin
            state_d     = ST_CLR;
            in_sel_d    = INSEL_RESET;
            num1_d      = '0;
            num2_d      = '0;
            op_d        = '0;
            res_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_sel_d = INSEL_IDLE;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        num1_d   = head_a;
                        num2_d   = head_b;
                        op_d     = head_op;
                        in_sel_d = INSEL_LOAD;
                        state_d  = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    in_sel_d = INSEL_PERSIST;
                    cnt_d    = CNT_W'(SETTLE_CYCLES - 1);
                    state_d  = ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        res_data_d  = alu_out;
                        res_state_d = alu_curr_state;
                        res_op_d    = op_q;
                        res_valid_d = 1'b1;
                        state_d     = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    // pop in the accepting edge so the next load follows with no IDLE gap
                    if (res_ready) begin
                        res_valid_d = 1'b0;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            num1_d   = head_a;
                            num2_d   = head_b;
                            op_d     = head_op;
                            in_sel_d = INSEL_LOAD;
                            state_d  = ST_LOAD;
                        end else begin
                            in_sel_d = INSEL_IDLE;
                            state_d  = ST_IDLE;
                        end
                    end
                end
                ST_CLR: begin
                    in_sel_d = INSEL_IDLE;
                    state_d  = ST_IDLE;
                end
                default: begin
                    in_sel_d = INSEL_IDLE;
                    state_d  = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            in_sel_q    <= INSEL_IDLE;
            num1_q      <= '0;
            num2_q      <= '0;
            op_q        <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            res_state_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_sel_q    <= in_sel_d;
            num1_q      <= num1_d;
            num2_q      <= num2_d;
            op_q        <= op_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
            res_state_q <= res_state_d;
        end
    end

    assign alu_in_sel  = in_sel_q;
    assign alu_num1    = num1_q;
    assign alu_num2    = num2_q;
    assign alu_out_sel = op_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_op      = res_op_q;
    assign res_state   = res_state_q;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a small registered ALU model feeds alu_out, expected results
// are queued when commands are issued and a negedge monitor checks every accepted result.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_a = '0;
    logic [7:0] cmd_b = '0;
    logic [5:0] cmd_op = '0;
    logic [2:0] alu_in_sel;
    logic [7:0] alu_num1, alu_num2;
    logic [5:0] alu_out_sel;
    logic [7:0] alu_out;
    logic [1:0] alu_curr_state;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [7:0] res_data;
    logic [5:0] res_op;
    logic [1:0] res_state;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] d;
        logic [5:0] op;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    alu_cmd_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_a          (cmd_a),
        .cmd_b          (cmd_b),
        .cmd_op         (cmd_op),
        .alu_in_sel     (alu_in_sel),
        .alu_num1       (alu_num1),
        .alu_num2       (alu_num2),
        .alu_out_sel    (alu_out_sel),
        .alu_out        (alu_out),
        .alu_curr_state (alu_curr_state),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .res_op         (res_op),
        .res_state      (res_state),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU model: result appears one edge after a load; state 1 after load, 2 while persisting
    logic [7:0] m_acc;
    logic [1:0] m_st;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc <= '0;
            m_st  <= '0;
        end else begin
            case (alu_in_sel)
                3'b001: begin m_acc <= '0; m_st <= 2'd0; end
                3'b010: begin
                    m_st <= 2'd1;
                    if (alu_out_sel == 6'd1)      m_acc <= alu_num1 + alu_num2;
                    else if (alu_out_sel == 6'd2) m_acc <= alu_num1 ^ alu_num2;
                    else                          m_acc <= '0;
                end
                3'b100: m_st <= 2'd2;
                default: ;
            endcase
        end
    end
    assign alu_out        = m_acc;
    assign alu_curr_state = m_st;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got data %0h op %0h, required no result", res_data, res_op);
            end else begin
                mon_e = exp_q.pop_front();
                chk("res_data", 32'(res_data), 32'(mon_e.d));
                chk("res_op", 32'(res_op), 32'(mon_e.op));
                chk("res_state", 32'(res_state), 32'd2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                        input logic [7:0] exp_d, input bit track);
        int t = 0;
        while (!cmd_ready && t < 50) begin tick(); t++; end
        chk("send_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
        @(posedge clk);
        if (track) exp_q.push_back('{exp_d, op});
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res_valid();
        int t = 0;
        while (!res_valid && t < 40) begin tick(); t++; end
        chk("res_valid_wait", 32'(res_valid), 32'd1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 100) begin tick(); t++; end
        chk("idle_wait", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int nt;
        int tv[3];

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_reset_busy", 32'(busy), 32'd0);

        // single command latency
        res_ready = 1'b1;
        send(8'h57, 8'h1A, 6'd1, 8'h71, 1'b1);
        tick();
        chk("e1_in_sel", 32'(alu_in_sel), 32'b010);
        chk("e1_num1", 32'(alu_num1), 32'h57);
        chk("e1_num2", 32'(alu_num2), 32'h1A);
        chk("e1_out_sel", 32'(alu_out_sel), 32'd1);
        tick();
        chk("e2_in_sel", 32'(alu_in_sel), 32'b100);
        chk("e2_res_valid", 32'(res_valid), 32'd0);
        tick();
        chk("e3_in_sel", 32'(alu_in_sel), 32'b100);
        chk("e3_res_valid", 32'(res_valid), 32'd0);
        tick();
        chk("e4_res_valid", 32'(res_valid), 32'd1);
        chk("e4_res_data", 32'(res_data), 32'h71);
        wait_idle();

        // asynchronous reset mid-operation, mid-cycle
        send(8'h11, 8'h22, 6'd1, 8'h00, 1'b0);
        tick();
        chk("pre_reset_in_sel", 32'(alu_in_sel), 32'b010);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_sel", 32'(alu_in_sel), 32'd0);
        chk("rst_num1", 32'(alu_num1), 32'd0);
        chk("rst_num2", 32'(alu_num2), 32'd0);
        chk("rst_out_sel", 32'(alu_out_sel), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_res_op", 32'(res_op), 32'd0);
        chk("rst_res_state", 32'(res_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rel_busy", 32'(busy), 32'd0);

        // backpressure: result held, FIFO fills, refused push at full during the HOLD pop
        res_ready = 1'b0;
        send(8'h10, 8'h20, 6'd1, 8'h30, 1'b1);
        wait_res_valid();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_stable", 32'({res_valid, res_data, res_op, res_state, alu_in_sel}),
                32'({1'b1, 8'h30, 6'd1, 2'd2, 3'b100}));
        end
        send(8'h01, 8'h02, 6'd1, 8'h03, 1'b1);
        send(8'hAA, 8'h0F, 6'd2, 8'hA5, 1'b1);
        send(8'hF0, 8'h20, 6'd1, 8'h10, 1'b1);
        send(8'h33, 8'h44, 6'd1, 8'h77, 1'b1);
        chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("full_count", 32'(dut.u_fifo.count), 32'd4);
        cmd_valid = 1'b1; cmd_a = 8'hEE; cmd_b = 8'hEE; cmd_op = 6'd1;
        res_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("hold_pop_in_sel", 32'(alu_in_sel), 32'b010);
        chk("hold_pop_count", 32'(dut.u_fifo.count), 32'd3);
        chk("hold_pop_res_valid", 32'(res_valid), 32'd0);
        wait_idle();
        chk("bp_queue_drained", 32'(exp_q.size()), 32'd0);

        // back-to-back throughput
        send(8'h00, 8'h01, 6'd1, 8'h01, 1'b1);
        c0 = cyc;
        send(8'hFF, 8'h01, 6'd1, 8'h00, 1'b1);
        send(8'h80, 8'h80, 6'd1, 8'h00, 1'b1);
        nt = 0;
        for (int i = 0; i < 20; i++) begin
            if (res_valid && nt < 3) begin tv[nt] = cyc; nt++; end
            tick();
        end
        chk("b2b_count", 32'(nt), 32'd3);
        chk("b2b_first_latency", 32'(tv[0] - c0), 32'd4);
        chk("b2b_gap1", 32'(tv[1] - tv[0]), 32'd4);
        chk("b2b_gap2", 32'(tv[2] - tv[1]), 32'd4);
        wait_idle();

        // flush in WAIT with two commands queued; a push in the flush cycle is dropped
        send(8'h11, 8'h11, 6'd1, 8'h00, 1'b0);
        send(8'h22, 8'h22, 6'd1, 8'h00, 1'b0);
        send(8'h33, 8'h33, 6'd1, 8'h00, 1'b0);
        chk("pre_flush_count", 32'(dut.u_fifo.count), 32'd2);
        chk("pre_flush_in_sel", 32'(alu_in_sel), 32'b100);
        flush = 1'b1;
        cmd_valid = 1'b1; cmd_a = 8'h44; cmd_b = 8'h44; cmd_op = 6'd1;
        tick();
        flush = 1'b0;
        cmd_valid = 1'b0;
        chk("clr_in_sel", 32'(alu_in_sel), 32'b001);
        chk("clr_num1", 32'(alu_num1), 32'd0);
        chk("clr_out_sel", 32'(alu_out_sel), 32'd0);
        chk("clr_count", 32'(dut.u_fifo.count), 32'd0);
        chk("clr_res_valid", 32'(res_valid), 32'd0);
        tick();
        chk("after_clr_in_sel", 32'(alu_in_sel), 32'b000);
        chk("after_clr_busy", 32'(busy), 32'd0);
        repeat (6) tick();
        chk("flush_no_result", 32'(res_valid), 32'd0);

        // simultaneous push and pop at count 2
        res_ready = 1'b0;
        send(8'h05, 8'h06, 6'd1, 8'h0B, 1'b1);
        wait_res_valid();
        send(8'h07, 8'h08, 6'd2, 8'h0F, 1'b1);
        send(8'h09, 8'h0A, 6'd1, 8'h13, 1'b1);
        chk("pp_count_before", 32'(dut.u_fifo.count), 32'd2);
        cmd_valid = 1'b1; cmd_a = 8'h0B; cmd_b = 8'h0C; cmd_op = 6'd1;
        res_ready = 1'b1;
        @(posedge clk);
        exp_q.push_back('{8'h17, 6'd1});
        #1;
        cmd_valid = 1'b0;
        chk("pp_count_after", 32'(dut.u_fifo.count), 32'd2);
        chk("pp_in_sel", 32'(alu_in_sel), 32'b010);
        wait_idle();
        chk("final_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream feeder for the 8-bit ALU datapath (`main`).
- Accepts operand/opcode commands over a valid/ready interface and buffers them in a small FIFO.
- Sequences the ALU's 3-bit in_sel control (persist/load/reset) and holds num1/num2/out_sel stable for a settle window.
- Captures the ALU result and ALU state, then presents them downstream on a second valid/ready interface.

Parameters:
- DATA_W, 8, operand and result width
- OP_W, 6, opcode width; drives ALU out_sel unchanged
- FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2
- SETTLE_CYCLES, 2, cycles the ALU inputs are held with persist before capture; at least 1

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; discard all queued and in-flight commands and reset the ALU
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept a command
- cmd_a  in  DATA_W  operand A, routed to ALU num1
- cmd_b  in  DATA_W  operand B, routed to ALU num2
- cmd_op  in  OP_W  operation select, routed to ALU out_sel
- alu_in_sel  out  3  ALU control: bit2 persist, bit1 load, bit0 reset
- alu_num1  out  DATA_W  registered operand A
- alu_num2  out  DATA_W  registered operand B
- alu_out_sel  out  OP_W  registered opcode
- alu_out  in  DATA_W  ALU result
- alu_curr_state  in  2  ALU current state
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts the result
- res_data  out  DATA_W  captured alu_out
- res_op  out  OP_W  opcode that produced res_data
- res_state  out  2  captured alu_curr_state
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty

Behaviour:
- Reset values (rst_n low, asynchronous): FIFO empty, FSM=IDLE, alu_in_sel=3'b000, alu_num1/alu_num2/alu_out_sel=0, res_valid=0, res_data/res_op/res_state=0.
- After reset, cmd_ready=1.
- Every output except cmd_ready and busy is registered.
- cmd_ready = !full, combinational from the FIFO count only. There is no bypass: when the FIFO is full, a pop in the same cycle does not enable a push.
- Push occurs on cmd_valid && cmd_ready. Simultaneous push and pop when not full leaves the count unchanged. Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, LOAD, WAIT, HOLD, CLR.
- IDLE:
  - alu_in_sel=000.
  - If the FIFO is non-empty: pop the head into alu_num1/alu_num2/alu_out_sel, then go to LOAD.
- LOAD:
  - alu_in_sel=010 for exactly one cycle.
  - Load the settle counter with SETTLE_CYCLES-1, then go to WAIT.
- WAIT:
  - alu_in_sel=100 (persist); operands are held.
  - Decrement the counter each cycle.
  - At the edge where the counter is 0: sample alu_out into res_data, alu_curr_state into res_state, alu_out_sel into res_op; set res_valid=1; go to HOLD.
- HOLD:
  - alu_in_sel=100; res_valid stays high and res_data/res_op/res_state are stable until res_ready.
  - On res_valid && res_ready: clear res_valid.
  - If the FIFO is non-empty, pop the next command in the same edge and go to LOAD (back-to-back). Otherwise go to IDLE.
- Latency: a command accepted at edge E0 into an empty FIFO with the FSM in IDLE produces the following.
  - alu_in_sel=010 after E1.
  - res_valid=1 after edge E(2+SETTLE_CYCLES), i.e. E4 at default parameters.
- Throughput: one result per 2+SETTLE_CYCLES cycles when res_ready is held high.
- flush (any state, highest priority after rst_n):
  - FIFO emptied; res_valid cleared; go to CLR.
  - A cmd push in the same cycle is dropped.
- CLR:
  - alu_in_sel=001 for exactly one cycle; alu_num1/alu_num2/alu_out_sel cleared to 0; then IDLE.
  - flush asserted while in CLR stays in CLR for another cycle.
- rst_n asserted mid-operation aborts immediately to the reset values. No partial result is ever presented.

Decomposition:
- Shared package alu_pkg holds:
  - DATA_W and OP_W
  - in_sel encodings: INSEL_IDLE=3'b000, INSEL_RESET=3'b001, INSEL_LOAD=3'b010, INSEL_PERSIST=3'b100
  - the FSM state enum
- One sub-module: alu_cmd_fifo (parameterised synchronous FIFO, push/pop/flush/full/empty/count).
- The FSM and ALU interface registers live in alu_cmd_sequencer.

Test Plan:
- Reset value check: hold rst_n low mid-cycle -> all registered outputs 0 asynchronously, cmd_ready=1 after release, busy=0.
- Single command: push a=8'h57, b=8'h1A, op=6'b000001 at E0 -> alu_in_sel 010 after E1, 100 after E2 and E3. Then res_valid=1 after E4 with res_data equal to alu_out at E4 and res_op=6'b000001.
- Backpressure: res_ready=0 for 10 cycles -> res_data/res_op/res_state stable and alu_in_sel=100. Push 4 further commands -> cmd_ready=0 after the fourth and the fifth is refused. Raise res_ready -> next alu_in_sel=010 on the following cycle, with no IDLE gap.
- Back-to-back: 3 commands (00/01, FF/01, 80/80) with res_ready=1 -> 3 results in order, res_valid pulses spaced 4 cycles apart.
- Flush mid-WAIT with 2 queued -> alu_in_sel=001 for one cycle, alu_num1=0, FIFO count=0, no res_valid, then IDLE and busy=0.
- Simultaneous push+pop at count=2 -> count stays 2. A push at full in the same cycle as a HOLD pop is refused (cmd_ready=0).
